cake_rand_gen: RTL and testbench

Upstream feeder of the cake placement register. Detects the snake head reaching the cake, or an explicit placement request. Draws bounded, grid-aligned random coordinates from a free-running LFSR. Delivers them on the two-cycle rand_num/rand_drive protocol the cake register consumes: X on the rand_drive cycle, Y on the following cycle.

---
 rtl/cake_rand_gen.sv | 149 ++++++++++++++
 tb/tb_cake_rand_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cake_rand_gen.sv
// Cake placement feeder: detects eat events / init requests, draws bounded grid-aligned
// coordinates from a free-running LFSR and issues them as X (with rand_drive) then Y.
module cake_rand_gen #(
  parameter logic [8:0]  X_MIN     = 9'd16,
  parameter logic [8:0]  X_MAX     = 9'd480,
  parameter logic [8:0]  Y_MIN     = 9'd16,
  parameter logic [8:0]  Y_MAX     = 9'd464,
  parameter int          GRID_LOG2 = 4,
  parameter int          MAX_TRY   = 15,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_en,
  input  logic        init_req,
  input  logic [11:0] head_x,
  input  logic [11:0] head_y,
  input  logic [11:0] cake_x,
  input  logic [11:0] cake_y,
  output logic [8:0]  rand_num,
  output logic        rand_drive,
  output logic        eat_pulse,
  output logic        busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GEN_X   = 3'd1;
  localparam logic [2:0] S_GEN_Y   = 3'd2;
  localparam logic [2:0] S_ISSUE_X = 3'd3;
  localparam logic [2:0] S_ISSUE_Y = 3'd4;
  localparam logic [2:0] S_SETTLE  = 3'd5;

  localparam int            RW        = (MAX_TRY < 1) ? 1 : $clog2(MAX_TRY + 1);
  localparam logic [RW-1:0] TRY_LAST  = RW'(MAX_TRY);
  localparam logic [8:0]    GRID_MASK = 9'h1FF << GRID_LOG2;
  localparam logic [9:0]    X_SUM     = {1'b0, X_MIN} + {1'b0, X_MAX};
  localparam logic [9:0]    Y_SUM     = {1'b0, Y_MIN} + {1'b0, Y_MAX};
  localparam logic [8:0]    X_FB      = X_SUM[9:1] & GRID_MASK;
  localparam logic [8:0]    Y_FB      = Y_SUM[9:1] & GRID_MASK;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    if (l == 16'd0) return SEED;
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [8:0] grid_align(input logic [8:0] v);
    return v & GRID_MASK;
  endfunction

  function automatic logic in_range(input logic [8:0] v, input logic [8:0] lo,
                                    input logic [8:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic [2:0]    state;
  logic [15:0]   lfsr;
  logic [RW-1:0] retry;
  logic          redo;
  logic          hit_d;
  logic [8:0]    cx;
  logic [8:0]    cy;

  logic       hit;
  logic       eat_ev;
  logic [8:0] cand;
  logic       x_ok;
  logic       y_ok;
  logic       at_last;
  logic [8:0] cy_nxt;
  logic       head_match;

  assign hit     = game_en && (head_x == cake_x) && (head_y == cake_y);
  assign eat_ev  = hit && !hit_d;
  assign cand    = grid_align(lfsr[8:0]);
  assign x_ok    = in_range(cand, X_MIN, X_MAX);
  assign y_ok    = in_range(cand, Y_MIN, Y_MAX);
  assign at_last = (retry == TRY_LAST);
  assign cy_nxt  = y_ok ? cand : Y_FB;
  // A coordinate pair landing exactly on the head is only meaningful when the head is on-screen.
  assign head_match = (head_x[11:9] == 3'd0) && (head_y[11:9] == 3'd0) &&
                      (cx == head_x[8:0]) && (cy_nxt == head_y[8:0]);
  assign busy = (state != S_IDLE);

  // Coordinate latches: pure data, no reset
  always_ff @(posedge clk) begin
    if (state == S_GEN_X && (x_ok || at_last)) cx <= x_ok ? cand : X_FB;
    if (state == S_GEN_Y && (y_ok || at_last)) cy <= cy_nxt;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lfsr       <= SEED;
      retry      <= '0;
      redo       <= 1'b0;
      hit_d      <= 1'b0;
      rand_num   <= 9'd0;
      rand_drive <= 1'b0;
      eat_pulse  <= 1'b0;
    end else begin
      lfsr       <= lfsr_step(lfsr);
      hit_d      <= (state == S_SETTLE) ? 1'b1 : hit;
      rand_drive <= 1'b0;
      eat_pulse  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (eat_ev || init_req) begin
            state     <= S_GEN_X;
            eat_pulse <= eat_ev;
            retry     <= '0;
            redo      <= 1'b0;
          end
        end
        S_GEN_X: begin
          if (x_ok || at_last) begin
            retry <= '0;
            state <= S_GEN_Y;
          end else begin
            retry <= retry + 1'b1;
          end
        end
        S_GEN_Y: begin
          if (y_ok || at_last) begin
            retry <= '0;
            if (head_match && !redo) begin
              redo  <= 1'b1;
              state <= S_GEN_X;
            end else begin
              state      <= S_ISSUE_X;
              rand_drive <= 1'b1;
              rand_num   <= cx;
            end
          end else begin
            retry <= retry + 1'b1;
          end
        end
        S_ISSUE_X: begin
          rand_num <= cy;
          state    <= S_ISSUE_Y;
        end
        S_ISSUE_Y: state <= S_SETTLE;
        S_SETTLE:  state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cake_rand_gen.sv
// Bench for cake_rand_gen: default-bounds instance plus a 256-only instance; stimulus pushes
// predicted placements, a negedge monitor pops and compares each issued X/Y pair.
module tb_cake_rand_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    logic [8:0] x;
    logic [8:0] y;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_en = 1'b0;
  logic        init_req = 1'b0;
  logic [11:0] head_x = 12'd0;
  logic [11:0] head_y = 12'd0;
  logic [11:0] cake_x = 12'd0;
  logic [11:0] cake_y = 12'd0;

  logic [8:0] rn [2];
  logic       rd [2];
  logic       ep [2];
  logic       bz [2];

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         eat_cnt [2] = '{0, 0};
  logic       have_x [2] = '{1'b0, 1'b0};
  logic [8:0] xcap [2];
  int         xcyc [2];
  logic [8:0] last_x0 = 9'd0;
  logic [8:0] last_y0 = 9'd0;
  logic [15:0] m_lfsr;
  exp_t       q0 [$];
  exp_t       q1 [$];

  cake_rand_gen u0 (
    .clk(clk), .rst(rst), .game_en(game_en), .init_req(init_req),
    .head_x(head_x), .head_y(head_y), .cake_x(cake_x), .cake_y(cake_y),
    .rand_num(rn[0]), .rand_drive(rd[0]), .eat_pulse(ep[0]), .busy(bz[0])
  );

  cake_rand_gen #(
    .X_MIN(9'd256), .X_MAX(9'd256), .Y_MIN(9'd256), .Y_MAX(9'd256)
  ) u1 (
    .clk(clk), .rst(rst), .game_en(game_en), .init_req(init_req),
    .head_x(head_x), .head_y(head_y), .cake_x(cake_x), .cake_y(cake_y),
    .rand_num(rn[1]), .rand_drive(rd[1]), .eat_pulse(ep[1]), .busy(bz[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] lstep(input logic [15:0] l);
    logic [15:0] v;
    v = l;
    if (v == 16'd0) return SEED;
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lstep(m_lfsr);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural placement model: l0 is the LFSR value in the cycle the trigger is sampled.
  task automatic predict(input logic [15:0] l0, input logic [11:0] hx, input logic [11:0] hy,
                         input logic [8:0] xmin, input logic [8:0] xmax,
                         input logic [8:0] ymin, input logic [8:0] ymax,
                         output logic [8:0] ox, output logic [8:0] oy, output int gen);
    logic [15:0] l;
    logic [8:0]  c, fbx, fby;
    bit          found, done;
    fbx = 9'((int'(xmin) + int'(xmax)) / 2) & 9'h1F0;
    fby = 9'((int'(ymin) + int'(ymax)) / 2) & 9'h1F0;
    l = lstep(l0);
    gen = 0;
    done = 0;
    ox = 9'd0;
    oy = 9'd0;
    for (int pass = 0; pass < 2 && !done; pass++) begin
      found = 0;
      for (int r = 0; r < 16 && !found; r++) begin
        c = l[8:0] & 9'h1F0;
        l = lstep(l);
        gen++;
        if (c >= xmin && c <= xmax) begin ox = c; found = 1; end
        else if (r == 15) begin ox = fbx; found = 1; end
      end
      found = 0;
      for (int r = 0; r < 16 && !found; r++) begin
        c = l[8:0] & 9'h1F0;
        l = lstep(l);
        gen++;
        if (c >= ymin && c <= ymax) begin oy = c; found = 1; end
        else if (r == 15) begin oy = fby; found = 1; end
      end
      if (!(pass == 0 && hx[11:9] == 3'd0 && hy[11:9] == 3'd0 &&
            ox == hx[8:0] && oy == hy[8:0])) done = 1;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    logic [8:0] ex, ey;
    int g;
    predict(m_lfsr, head_x, head_y, 9'd16, 9'd480, 9'd16, 9'd464, ex, ey, g);
    e.x = ex; e.y = ey; e.cyc = cyc + 1 + g;
    q0.push_back(e);
    predict(m_lfsr, head_x, head_y, 9'd256, 9'd256, 9'd256, 9'd256, ex, ey, g);
    e.x = ex; e.y = ey; e.cyc = cyc + 1 + g;
    q1.push_back(e);
  endtask

  task automatic mon(input int i);
    exp_t e;
    bit got;
    if (ep[i]) eat_cnt[i]++;
    if (have_x[i]) begin
      have_x[i] = 1'b0;
      chk(i == 0 ? "drive_low_on_y0" : "drive_low_on_y1", int'(rd[i]), 0);
      got = 0;
      if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
      if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
      if (!got) chk(i == 0 ? "unexpected_place0" : "unexpected_place1", 1, 0);
      else begin
        chk(i == 0 ? "x0" : "x1", int'(xcap[i]), int'(e.x));
        chk(i == 0 ? "y0" : "y1", int'(rn[i]), int'(e.y));
        chk(i == 0 ? "drive_cycle0" : "drive_cycle1", xcyc[i], e.cyc);
      end
      if (i == 0) begin
        chk("x0_legal", int'(xcap[0] >= 9'd16 && xcap[0] <= 9'd480 && xcap[0][3:0] == 4'd0), 1);
        chk("y0_legal", int'(rn[0] >= 9'd16 && rn[0] <= 9'd464 && rn[0][3:0] == 4'd0), 1);
        cake_x  = {3'b000, xcap[0]};
        cake_y  = {3'b000, rn[0]};
        last_x0 = xcap[0];
        last_y0 = rn[0];
      end
    end else if (rd[i]) begin
      have_x[i] = 1'b1;
      xcap[i]   = rn[i];
      xcyc[i]   = cyc;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bz[0] || bz[1] || have_x[0] || have_x[1]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", int'(n < 300), 1);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_rand_num"}, int'(rn[i]), 0);
      chk({tag, "_rand_drive"}, int'(rd[i]), 0);
      chk({tag, "_eat_pulse"}, int'(ep[i]), 0);
      chk({tag, "_busy"}, int'(bz[i]), 0);
    end
    chk({tag, "_lfsr"}, int'(u0.lfsr), int'(SEED));
  endtask

  initial begin
    int e0, e1, g;
    logic [8:0] fx, fy;

    // Reset state
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // init_req with game disabled: placement, no eat_pulse
    e0 = eat_cnt[0]; e1 = eat_cnt[1];
    push_exp();
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    chk("init_busy", int'(bz[0]), 1);
    chk("init_no_eat", int'(ep[0]), 0);
    wait_idle();
    chk("init_eat_count0", eat_cnt[0] - e0, 0);
    chk("init_eat_count1", eat_cnt[1] - e1, 0);
    chk("rand_num_holds", int'(rn[0]), int'(last_y0));

    // Head resting on cake: one event, one placement
    e0 = eat_cnt[0]; e1 = eat_cnt[1];
    game_en = 1'b1;
    head_x = cake_x; head_y = cake_y;
    push_exp();
    @(negedge clk);
    chk("eat_pulse_latency", int'(ep[0]), 1);
    repeat (40) @(negedge clk);
    wait_idle();
    chk("rest_eat_count0", eat_cnt[0] - e0, 1);
    chk("rest_eat_count1", eat_cnt[1] - e1, 1);

    // Eat and init together, then a second eat while busy
    e0 = eat_cnt[0]; e1 = eat_cnt[1];
    head_x = cake_x; head_y = cake_y;
    init_req = 1'b1;
    push_exp();
    @(negedge clk);
    init_req = 1'b0;
    chk("both_eat_pulse0", int'(ep[0]), 1);
    chk("both_eat_pulse1", int'(ep[1]), 1);
    head_x = 12'd0; head_y = 12'd0;
    @(negedge clk);
    head_x = cake_x; head_y = cake_y;
    wait_idle();
    chk("both_eat_count0", eat_cnt[0] - e0, 1);
    chk("both_eat_count1", eat_cnt[1] - e1, 1);

    // Reset mid-placement, then a normal placement
    game_en = 1'b0;
    head_x = 12'd0; head_y = 12'd0;
    repeat (2) @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    chk("pre_reset_busy", int'(bz[0]), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_exp();
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    wait_idle();

    // Head placed on the first candidate: forces one regeneration
    predict(m_lfsr, 12'hFFF, 12'hFFF, 9'd16, 9'd480, 9'd16, 9'd464, fx, fy, g);
    head_x = {3'b000, fx}; head_y = {3'b000, fy};
    push_exp();
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    wait_idle();
    chk("regen_differs", int'({last_x0, last_y0} != {fx, fy}), 1);

    // Head at the only legal point of the narrow instance: second result accepted anyway
    head_x = 12'd256; head_y = 12'd256;
    push_exp();
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
